// File: rtl/sort_batch_issuer.sv
// Batches up to 8 request keys, sorts them in one registered step and drains them ascending.
// sort_eight is a purely combinational odd-even transposition network over 8 keys.

module sort_eight #(
  parameter int DATA_W = 12
) (
  input  logic [7:0][DATA_W-1:0] keys_i,
  output logic [7:0][DATA_W-1:0] sorted_o
);

  logic [DATA_W-1:0] tmp;

  // 8 alternating even/odd compare-exchange rounds fully sort 8 entries.
  always_comb begin
    sorted_o = keys_i;
    tmp      = '0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 7; i++) begin
        if (((i % 2) == (r % 2)) && (sorted_o[i] > sorted_o[i+1])) begin
          tmp           = sorted_o[i];
          sorted_o[i]   = sorted_o[i+1];
          sorted_o[i+1] = tmp;
        end
      end
    end
  end

endmodule

module sort_batch_issuer #(
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] SORT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              n_q, n_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    rdy_en_q;
  logic [7:0][DATA_W-1:0]  slot_q, slot_d;
  logic [7:0][DATA_W-1:0]  buf_q;
  logic [7:0][DATA_W-1:0]  sorted;
  logic                    accept;
  logic                    out_hs;

  sort_eight #(.DATA_W(DATA_W)) u_sort (
    .keys_i   (slot_q),
    .sorted_o (sorted)
  );

  // rdy_en_q keeps in_ready low during reset and for the first cycle after release.
  assign in_ready  = rdy_en_q && ((state_q == IDLE) || ((state_q == FILL) && (cnt_q < 4'd8)));
  assign out_valid = (state_q == DRAIN);
  assign out_addr  = (state_q == DRAIN) ? buf_q[idx_q[2:0]] : '0;
  assign out_last  = (state_q == DRAIN) && (idx_q == (n_q - 4'd1));
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    timer_d = timer_q;
    slot_d  = slot_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          slot_d[0] = in_addr;
          cnt_d     = 4'd1;
          timer_d   = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (timer_q != {TW{1'b1}}) timer_d = timer_q + 1'b1;
        if (accept) begin
          slot_d[cnt_q[2:0]] = in_addr;
          cnt_d              = cnt_q + 4'd1;
        end
        // A key accepted on the closing edge still lands in this batch.
        if ((accept && (cnt_q == 4'd7)) || (timer_q == TW'(TIMEOUT - 1)) || flush)
          state_d = SORT;
      end
      SORT: begin
        n_d     = cnt_q;
        idx_d   = 4'd0;
        state_d = DRAIN;
      end
      default: begin
        if (out_hs) begin
          idx_d = idx_q + 4'd1;
          if (out_last) begin
            slot_d  = '1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 4'd0;
      n_q      <= 4'd0;
      timer_q  <= '0;
      rdy_en_q <= 1'b0;
      slot_q   <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      timer_q  <= timer_d;
      rdy_en_q <= 1'b1;
      slot_q   <= slot_d;
    end
  end

  // Sorted snapshot; only read while draining, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == SORT) buf_q <= sorted;
  end

endmodule

// File: tb/tb_sort_batch_issuer.sv
// Randomized and directed bench for sort_batch_issuer with a transaction-level batch model.

module tb_sort_batch_issuer;

  localparam int DATA_W  = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_addr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_addr;
  logic              out_last;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] keys_q[$];

  sort_batch_issuer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_key();
    int sel;
    sel = $urandom_range(3, 0);
    if (sel == 0) return 12'hFFF;
    if (sel == 1) return 12'h000;
    return DATA_W'($urandom);
  endfunction

  // Feeds keys_q, predicts where the batch closes (8 keys, flush while filling, or
  // TIMEOUT edges after the first accept), then checks the ascending drain.
  // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run_batch(input bit use_flush, input int gap_max, input int rmode,
                           input int abort_after);
    logic [DATA_W-1:0] exp_q[$];
    int  n, sent, gap, since, i, cyc;
    bit  started, closed;
    n       = keys_q.size();
    exp_q   = keys_q;
    exp_q.sort();
    sent    = 0;
    since   = 0;
    started = 1'b0;
    closed  = 1'b0;
    gap     = $urandom_range(gap_max, 0);
    while (!closed) begin
      @(negedge clk);
      chk("fill_in_ready", 32'(in_ready), 32'(1));
      chk("fill_busy", 32'(busy), 32'(started));
      chk("fill_out_valid", 32'(out_valid), 32'(0));
      in_valid = 1'b0;
      flush    = 1'b0;
      if (sent < n) begin
        if (gap == 0) begin
          in_valid = 1'b1;
          in_addr  = keys_q[sent];
          if (use_flush && (sent == n - 1)) flush = 1'b1;
        end else begin
          gap--;
        end
      end
      @(posedge clk);
      if (started) since++;
      if (in_valid) begin
        if (started && flush) closed = 1'b1;
        sent++;
        if (!started) begin
          started = 1'b1;
          since   = 0;
        end
        if (sent == 8) closed = 1'b1;
        gap = $urandom_range(gap_max, 0);
      end
      if (started && (since == TIMEOUT)) closed = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'($urandom);
    in_addr  = DATA_W'($urandom);
    flush    = 1'b0;
    chk("sort_out_valid", 32'(out_valid), 32'(0));
    chk("sort_in_ready", 32'(in_ready), 32'(0));
    chk("sort_busy", 32'(busy), 32'(1));
    i   = 0;
    cyc = 0;
    while (i < n) begin
      @(negedge clk);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom);
      endcase
      in_valid = 1'($urandom);
      chk("drain_out_valid", 32'(out_valid), 32'(1));
      chk("drain_out_addr", 32'(out_addr), 32'(exp_q[i]));
      chk("drain_out_last", 32'(out_last), 32'(i == n - 1));
      chk("drain_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      if (out_ready) i++;
      cyc++;
      if ((abort_after >= 0) && (i == abort_after)) begin
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_addr", 32'(out_addr), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 32'(in_ready), 32'(1));
        chk("rel_busy", 32'(busy), 32'(0));
        out_ready = 1'b0;
        return;
      end
      if (cyc > 200) begin
        chk("drain_timeout", 32'(i), 32'(n));
        break;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("done_out_valid", 32'(out_valid), 32'(0));
    chk("done_busy", 32'(busy), 32'(0));
    chk("done_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    int nk;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_addr   = '0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'(0));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_last", 32'(out_last), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_out_addr", 32'(out_addr), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_low", 32'(in_ready), 32'(0));
    @(negedge clk);
    chk("release_in_ready_high", 32'(in_ready), 32'(1));

    keys_q = '{12'd800, 12'd700, 12'd600, 12'd500, 12'd400, 12'd300, 12'd200, 12'd100};
    run_batch(1'b0, 0, 0, -1);

    keys_q = '{12'h030, 12'h010, 12'h020};
    run_batch(1'b0, 0, 0, -1);

    repeat (3) begin
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_flush_busy", 32'(busy), 32'(0));
    end
    @(negedge clk);
    flush = 1'b0;
    keys_q = '{12'd5, 12'd3, 12'd4};
    run_batch(1'b1, 0, 0, -1);

    keys_q.delete();
    for (int k = 0; k < 8; k++) keys_q.push_back(rand_key());
    run_batch(1'b0, 0, 1, -1);

    keys_q = '{12'hFFF, 12'h000, 12'hFFF, 12'h7FF};
    run_batch(1'b1, 0, 2, -1);

    keys_q.delete();
    for (int k = 0; k < 8; k++) keys_q.push_back(rand_key());
    run_batch(1'b0, 0, 0, 3);
    keys_q = '{12'd9, 12'd1};
    run_batch(1'b1, 0, 0, -1);

    for (int b = 0; b < 30; b++) begin
      keys_q.delete();
      nk = $urandom_range(8, 1);
      for (int k = 0; k < nk; k++) keys_q.push_back(rand_key());
      run_batch(1'($urandom), 1, 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
